mem_pattern_gen: RTL and testbench

Synthesizable, parametrised memory traffic generator and checker for the dual-read-port memory. It replaces fixed-delay stimulus with a start/done sequencer that writes a programmable data pattern over an address range and reads each word back through port A or port B. It compares each read-back value against the pattern and reports error count and first failing address. It sits between the test controller and the memory's write/read-select/address/data pins.

---
 rtl/mem_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_mem_pattern_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_pattern_gen.sv
// Memory traffic generator/checker: writes a pattern over an address range,
// reads each word back on alternating ports and tallies mismatches.
module mem_pattern_gen #(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int CW   = 11,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   base_addr,
  input  logic [CW-1:0]   count,
  input  logic [DW-1:0]   seed,
  input  logic [DW-1:0]   rdata_a,
  input  logic [DW-1:0]   rdata_b,
  output logic [DW-1:0]   validdata,
  output logic            iWriteEnable,
  output logic            Readtoa,
  output logic            Readtob,
  output logic [AW-1:0]   iAddress,
  output logic            busy,
  output logic            done,
  output logic [ERRW-1:0] error_count,
  output logic [AW-1:0]   first_err_addr,
  output logic            err_seen
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] CMP  = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  localparam int PW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] DWV   = DW'(DW);
  localparam logic [PW-1:0] WLAST = PW'(DW - 1);

  logic [2:0]    state;
  logic [1:0]    mode_q;
  logic [DW-1:0] seed_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx;
  logic [AW-1:0] addr;
  // walking-one bit position, tracks (idx + seed) mod DW
  logic [PW-1:0] wpos;

  logic [PW-1:0] wpos0;
  logic [PW-1:0] wpos_nx;
  logic [CW-1:0] idx_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] rd_sel;
  logic          mism;

  function automatic logic [DW-1:0] pat(
    input logic [1:0]    m,
    input logic [DW-1:0] s,
    input logic [CW-1:0] k,
    input logic [AW-1:0] a,
    input logic [PW-1:0] wp
  );
    case (m)
      2'd0:    pat = s + DW'(k);
      2'd1:    pat = DW'(1) << wp;
      2'd2:    pat = DW'(a);
      default: pat = ~DW'(a);
    endcase
  endfunction

  assign wpos0   = PW'(seed % DWV);
  assign wpos_nx = (wpos == WLAST) ? '0 : wpos + PW'(1);
  assign idx_nx  = idx + CW'(1);
  assign addr_nx = addr + AW'(1);
  // even vectors were read on port A, odd on port B
  assign rd_sel  = idx[0] ? rdata_b : rdata_a;
  assign mism    = (rd_sel != validdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= '0;
      seed_q         <= '0;
      cnt_q          <= '0;
      idx            <= '0;
      addr           <= '0;
      wpos           <= '0;
      validdata      <= '0;
      iWriteEnable   <= 1'b0;
      Readtoa        <= 1'b0;
      Readtob        <= 1'b0;
      iAddress       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            seed_q         <= seed;
            cnt_q          <= count;
            idx            <= '0;
            addr           <= base_addr;
            wpos           <= wpos0;
            error_count    <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            if (count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state        <= WR;
              busy         <= 1'b1;
              iWriteEnable <= 1'b1;
              iAddress     <= base_addr;
              validdata    <= pat(mode, seed, '0, base_addr, wpos0);
            end
          end
        end
        WR: begin
          state        <= RD;
          iWriteEnable <= 1'b0;
          Readtoa      <= ~idx[0];
          Readtob      <= idx[0];
        end
        RD: begin
          state   <= CMP;
          Readtoa <= 1'b0;
          Readtob <= 1'b0;
        end
        CMP: begin
          if (mism) begin
            if (error_count != '1)
              error_count <= error_count + ERRW'(1);
            if (!err_seen) begin
              err_seen       <= 1'b1;
              first_err_addr <= addr;
            end
          end
          idx  <= idx_nx;
          addr <= addr_nx;
          wpos <= wpos_nx;
          if (idx_nx == cnt_q) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= WR;
            iWriteEnable <= 1'b1;
            iAddress     <= addr_nx;
            validdata    <= pat(mode_q, seed_q, idx_nx, addr_nx, wpos_nx);
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_gen.sv
// Randomised bench for mem_pattern_gen against a vector-list reference model
// and an ideal registered-read memory with optional fault injection.
module tb_mem_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic [7:0]  seed;
  logic [7:0]  rdata_a;
  logic [7:0]  rdata_b;
  logic [7:0]  validdata;
  logic        iWriteEnable;
  logic        Readtoa;
  logic        Readtob;
  logic [9:0]  iAddress;
  logic        busy;
  logic        done;
  logic [7:0]  error_count;
  logic [9:0]  first_err_addr;
  logic        err_seen;

  int n_checks = 0;
  int n_pass   = 0;

  bit fault_b   = 1'b0;
  bit fault_all = 1'b0;

  logic [7:0] mem [0:1023];
  logic [7:0] ra_q = '0;
  logic [7:0] rb_q = '0;

  always #5 clk = ~clk;

  mem_pattern_gen #(.DW(8), .AW(10), .CW(11), .ERRW(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .base_addr(base_addr),
    .count(count),
    .seed(seed),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b),
    .validdata(validdata),
    .iWriteEnable(iWriteEnable),
    .Readtoa(Readtoa),
    .Readtob(Readtob),
    .iAddress(iAddress),
    .busy(busy),
    .done(done),
    .error_count(error_count),
    .first_err_addr(first_err_addr),
    .err_seen(err_seen)
  );

  always @(posedge clk) begin
    if (iWriteEnable) mem[iAddress] <= validdata;
    if (Readtoa) ra_q <= mem[iAddress];
    if (Readtob) rb_q <= mem[iAddress];
  end

  assign rdata_a = fault_all ? ~ra_q : ra_q;
  assign rdata_b = fault_all ? ~rb_q : (rb_q | {7'b0, fault_b});

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int pdat(input int m, input int s, input int k,
                              input int a);
    case (m)
      0:       return (s + k) & 255;
      1:       return 1 << ((k + s) % 8);
      2:       return a & 255;
      default: return (~a) & 255;
    endcase
  endfunction

  // value the faulty memory hands back for vector k holding data d
  function automatic int mret(input int k, input int d);
    if (fault_all) return (~d) & 255;
    if (fault_b && (k % 2 == 1)) return d | 1;
    return d;
  endfunction

  task automatic run(input int m, input int b, input int n, input int s,
                     input bit hold, input string nm);
    int errs, first, len, k, ph, a, d;
    logic [4:0] ectl;
    errs  = 0;
    first = 0;
    for (int j = 0; j < n; j++) begin
      a = (b + j) % 1024;
      d = pdat(m, s, j, a);
      if (mret(j, d) != d) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    if (errs > 255) errs = 255;
    len = 3 * n + 1;
    @(negedge clk);
    mode      = m[1:0];
    base_addr = b[9:0];
    count     = n[10:0];
    seed      = s[7:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == len) begin
        ectl = 5'b00001;
      end else begin
        k  = (c - 1) / 3;
        ph = (c - 1) % 3;
        a  = (b + k) % 1024;
        d  = pdat(m, s, k, a);
        ectl = {ph == 0, ph == 1 && k % 2 == 0, ph == 1 && k % 2 == 1,
                1'b1, 1'b0};
        check({nm, ".addr"}, iAddress, a);
        if (ph < 2) check({nm, ".wdata"}, validdata, d);
      end
      check({nm, ".ctl"}, {iWriteEnable, Readtoa, Readtob, busy, done}, ectl);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check({nm, ".idle"}, {iWriteEnable, Readtoa, Readtob, busy, done}, 0);
    check({nm, ".errcnt"}, error_count, errs);
    check({nm, ".errseen"}, err_seen, errs != 0);
    check({nm, ".firsterr"}, first_err_addr, first);
  endtask

  initial begin
    int m, b, n, s;
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = '0;
    base_addr = '0;
    count     = '0;
    seed      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out0", {validdata, iWriteEnable, Readtoa, Readtob, iAddress,
                       busy, done}, 0);
    check("rst.out1", {error_count, first_err_addr, err_seen}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2, 0, 4, 0, 1'b0, "addr4");
    run(1, 10, 9, 0, 1'b0, "walk9");
    run(0, 1023, 2, 'h10, 1'b0, "wrap");
    fault_b = 1'b1;
    run(2, 0, 4, 0, 1'b0, "stuckb");
    fault_b = 1'b0;
    run(3, 5, 0, 0, 1'b0, "cnt0");
    run(3, 100, 3, 0, 1'b1, "hold");
    fault_all = 1'b1;
    run(0, 7, 300, 'h5a, 1'b0, "sat");
    fault_all = 1'b0;

    // abandon a run during the RD cycle of vector 2
    @(negedge clk);
    mode      = 2'd0;
    base_addr = 10'd50;
    count     = 11'd5;
    seed      = 8'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid.rdsel", {Readtoa, Readtob, iAddress}, {2'b10, 10'd52});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.out0", {validdata, iWriteEnable, Readtoa, Readtob, iAddress,
                       busy, done}, 0);
    check("mid.out1", {error_count, first_err_addr, err_seen}, 0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      check("mid.nodone", {busy, done}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 50, 5, 3, 1'b0, "after");

    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(0, 3);
      b = $urandom_range(0, 1023);
      n = $urandom_range(0, 20);
      s = $urandom_range(0, 255);
      fault_b = 1'($urandom_range(0, 1));
      run(m, b, n, s, 1'($urandom_range(0, 1)), "rand");
    end
    fault_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
